// File: rtl/rvv_pkg.sv
// Shared constants, encodings and state type for the RVV unit-stride load/store unit.
// Also holds the transfer-length helper used by the FSM.
package rvv_pkg;

    localparam int VLEN  = 128;
    localparam int BUS_W = 32;
    localparam int BEATS = VLEN / BUS_W;
    localparam int NREG  = 32;

    localparam logic [2:0] SEW_E8  = 3'b000;
    localparam logic [2:0] SEW_E16 = 3'b001;
    localparam logic [2:0] SEW_E32 = 3'b010;
    localparam logic [2:0] LMUL_M1 = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_REQ     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } vlsu_state_e;

    // Bytes to move: vl scaled by element size, clamped to one register.
    function automatic logic [4:0] calc_nbytes(input logic [8:0] vl, input logic [2:0] vsew);
        logic [10:0] w_scaled;
        w_scaled = {2'b00, vl} << vsew;
        return (w_scaled > 11'd16) ? 5'd16 : w_scaled[4:0];
    endfunction

endpackage

// File: rtl/rvv_vlsu_bytemask.sv
// Byte enables for one 32-bit beat: byte b of beat k is live when 4k+b < nbytes.
module rvv_vlsu_bytemask (
    input  logic [4:0] i_nbytes,
    input  logic [1:0] i_beat,
    output logic [3:0] o_be
);

    always_comb begin
        o_be = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            o_be[b] = (5'({i_beat, 2'(b)}) < i_nbytes);
        end
    end

endmodule

// File: rtl/rvv_vlsu_unit.sv
// Unit-stride vle/vse engine: moves up to 16 bytes between a 32-bit memory port and one
// 128-bit vector register. Memory handshake: a beat transfers on a cycle with mem_req && mem_gnt.
module rvv_vlsu_unit
    import rvv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_store,
    input  logic [4:0]    cmd_vreg,
    input  logic [31:0]   cmd_base,
    input  logic [8:0]    vl,
    input  logic [6:0]    vtype,
    output logic [4:0]    rf_ra,
    input  logic [127:0]  rf_rd,
    output logic [4:0]    rf_wa,
    output logic [127:0]  rf_wd,
    output logic          rf_wen,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          done_valid,
    output logic          done_err,
    output vlsu_state_e   dbg_state
);

    vlsu_state_e  r_state;
    vlsu_state_e  w_next;
    logic         r_store;
    logic [4:0]   r_vreg;
    logic [31:0]  r_base;
    logic [8:0]   r_vl;
    logic [6:0]   r_vtype;
    logic [127:0] r_buf;
    logic [1:0]   r_beat;
    logic         r_err;

    logic [4:0]   w_nbytes;
    logic [4:0]   w_nbeats;
    logic         w_last;
    logic         w_bad;
    logic [3:0]   w_be;
    logic [31:0]  w_word;

    assign w_nbytes = calc_nbytes(r_vl, r_vtype[5:3]);
    assign w_nbeats = (w_nbytes + 5'd3) >> 2;
    assign w_last   = ({3'b000, r_beat} == (w_nbeats - 5'd1));
    assign w_bad    = !r_vtype[6] || (r_vtype[5:3] > SEW_E32) ||
                      (r_vtype[2:0] != LMUL_M1) || (r_base[1:0] != 2'b00);
    assign w_word   = r_buf[{r_beat, 5'b00000} +: 32];

    rvv_vlsu_bytemask u_bytemask (
        .i_nbytes (w_nbytes),
        .i_beat   (r_beat),
        .o_be     (w_be)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (cmd_valid) w_next = ST_CHECK;
            ST_CHECK:   w_next = (w_bad || w_nbytes == 5'd0) ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: w_next = ST_REQ;
            ST_REQ: begin
                if (mem_gnt) begin
                    if (!r_store)    w_next = ST_WAIT;
                    else if (w_last) w_next = ST_DONE;
                end
            end
            ST_WAIT:    if (mem_rvalid) w_next = w_last ? ST_WRITE : ST_REQ;
            ST_WRITE:   w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_store <= 1'b0;
            r_vreg  <= 5'd0;
            r_base  <= 32'd0;
            r_vl    <= 9'd0;
            r_vtype <= 7'd0;
            r_buf   <= 128'd0;
            r_beat  <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_store <= cmd_store;
                        r_vreg  <= cmd_vreg;
                        r_base  <= cmd_base;
                        r_vl    <= vl;
                        r_vtype <= vtype;
                        r_beat  <= 2'd0;
                        r_err   <= 1'b0;
                    end
                end
                ST_CHECK:   r_err <= w_bad;
                // Loads merge into the old register value so tail bytes stay undisturbed.
                ST_CAPTURE: r_buf <= rf_rd;
                ST_REQ:     if (mem_gnt && r_store) r_beat <= r_beat + 2'd1;
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_be[b]) r_buf[{r_beat, 2'(b), 3'b000} +: 8] <= mem_rdata[8*b +: 8];
                        end
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign rf_ra      = r_vreg;
    assign rf_wen     = (r_state == ST_WRITE);
    assign rf_wa      = rf_wen ? r_vreg : 5'd0;
    assign rf_wd      = rf_wen ? r_buf : 128'd0;
    assign mem_req    = (r_state == ST_REQ);
    assign mem_we     = mem_req && r_store;
    assign mem_addr   = mem_req ? (r_base + {28'd0, r_beat, 2'b00}) : 32'd0;
    assign mem_be     = mem_req ? w_be : 4'b0000;
    assign mem_wdata  = mem_we ? w_word : 32'd0;
    assign done_valid = (r_state == ST_DONE);
    assign done_err   = done_valid && r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_rvv_vlsu_unit.sv
// Directed bench for rvv_vlsu_unit: a driver issues commands and pushes expected
// memory beats, register writes and completions; a negedge monitor pops and compares.
module tb_rvv_vlsu_unit;
    import rvv_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_store;
    logic [4:0]   cmd_vreg;
    logic [31:0]  cmd_base;
    logic [8:0]   vl;
    logic [6:0]   vtype;
    logic [4:0]   rf_ra, rf_wa;
    logic [127:0] rf_rd, rf_wd;
    logic         rf_wen;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_be;
    logic         done_valid, done_err;
    vlsu_state_e  dbg_state;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [4:0]   wa;
        logic [127:0] wd;
    } rf_exp_t;

    typedef struct {
        logic err;
        int   cyc;
    } done_exp_t;

    mem_exp_t  exp_mem_q[$];
    rf_exp_t   exp_rf_q[$];
    done_exp_t exp_done_q[$];
    mem_exp_t  m_head;
    rf_exp_t   r_head;
    done_exp_t d_head;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] rf_model [32];
    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  stall_addr = 32'hFFFF_FFFF;
    int           stall_len  = 0;
    int           stall_cnt  = 0;
    logic         gnt_blk;

    localparam logic [127:0] V7 = 128'h77776666_55554444_33332222_11110000;

    rvv_vlsu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_store  (cmd_store),
        .cmd_vreg   (cmd_vreg),
        .cmd_base   (cmd_base),
        .vl         (vl),
        .vtype      (vtype),
        .rf_ra      (rf_ra),
        .rf_rd      (rf_rd),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_wen     (rf_wen),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done_valid (done_valid),
        .done_err   (done_err),
        .dbg_state  (dbg_state)
    );

    // clock / reset-related infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file model
    assign rf_rd = rf_model[rf_ra];
    always @(posedge clk) if (rst && rf_wen) rf_model[rf_wa] <= rf_wd;

    // memory model: grant same cycle unless stalled, read data one cycle later
    always_comb gnt_blk = (mem_addr == stall_addr) && (stall_cnt < stall_len);
    assign mem_gnt = mem_req && !gnt_blk;
    always @(posedge clk) if (mem_req && gnt_blk) stall_cnt <= stall_cnt + 1;

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (rst && mem_req && mem_gnt && !mem_we) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) begin
                if (exp_mem_q.size() == 0) begin
                    chk("mem_req_unexpected", {127'd0, mem_req}, 128'd0);
                end else begin
                    m_head = exp_mem_q[0];
                    chk("mem_addr", {96'd0, mem_addr}, {96'd0, m_head.addr});
                    chk("mem_be", {124'd0, mem_be}, {124'd0, m_head.be});
                    chk("mem_we", {127'd0, mem_we}, {127'd0, m_head.we});
                    if (m_head.we) chk("mem_wdata", {96'd0, mem_wdata}, {96'd0, m_head.wdata});
                    if (mem_gnt) void'(exp_mem_q.pop_front());
                end
            end
            if (rf_wen) begin
                if (exp_rf_q.size() == 0) begin
                    chk("rf_wen_unexpected", {127'd0, rf_wen}, 128'd0);
                end else begin
                    r_head = exp_rf_q.pop_front();
                    chk("rf_wa", {123'd0, rf_wa}, {123'd0, r_head.wa});
                    chk("rf_wd", rf_wd, r_head.wd);
                end
            end
            if (done_valid) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", {127'd0, done_valid}, 128'd0);
                end else begin
                    d_head = exp_done_q.pop_front();
                    chk("done_err", {127'd0, done_err}, {127'd0, d_head.err});
                    chk("done_cycle", 128'(cyc), 128'(d_head.cyc));
                end
            end
        end
    end

    // driver tasks
    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
        exp_mem_q.push_back('{we: we, addr: addr, be: be, wdata: wdata});
    endtask

    task automatic exp_rf(input logic [4:0] wa, input logic [127:0] wd);
        exp_rf_q.push_back('{wa: wa, wd: wd});
    endtask

    // Caller is #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input logic st, input logic [4:0] vr, input logic [31:0] base,
                         input logic [8:0] vlv, input logic [6:0] vt, input logic err,
                         input int lat);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", {127'd0, cmd_ready}, 128'd1);
        cmd_valid = 1'b1;
        cmd_store = st;
        cmd_vreg  = vr;
        cmd_base  = base;
        vl        = vlv;
        vtype     = vt;
        exp_done_q.push_back('{err: err, cyc: cyc + lat});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        vl        = $urandom_range(511, 0);
        vtype     = 7'($urandom_range(127, 0));
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_mem_q.size() + exp_rf_q.size() + exp_done_q.size()) != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 128'(exp_mem_q.size() + exp_rf_q.size() + exp_done_q.size()), 128'd0);
        exp_mem_q.delete();
        exp_rf_q.delete();
        exp_done_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_store = 1'b0;
        cmd_vreg  = 5'd0;
        cmd_base  = 32'd0;
        vl        = 9'd0;
        vtype     = 7'd0;
        for (int i = 0; i < 32; i++) rf_model[i] = {4{32'h0BAD_0000 | 32'(i)}};
        rf_model[3] = {128{1'b1}};
        rf_model[7] = V7;
        mem[32'h100] = 32'h11111111;
        mem[32'h104] = 32'h22222222;
        mem[32'h108] = 32'h33333333;
        mem[32'h10C] = 32'h44444444;
        mem[32'h200] = 32'hA0A1A2A3;
        mem[32'h204] = 32'hB0B1B2B3;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        chk("rst_mem_req", {127'd0, mem_req}, 128'd0);
        chk("rst_rf_wen", {127'd0, rf_wen}, 128'd0);
        chk("rst_done_valid", {127'd0, done_valid}, 128'd0);
        chk("rst_rf_ra", {123'd0, rf_ra}, 128'd0);
        chk("rst_state", {125'd0, dbg_state}, {125'd0, ST_IDLE});
        rst = 1'b1;
        @(posedge clk); #1;

        // load e32 vl=4 into v1
        for (int k = 0; k < 4; k++) exp_mem(1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'd0);
        exp_rf(5'd1, 128'h44444444_33333333_22222222_11111111);
        issue(1'b0, 5'd1, 32'h100, 9'd4, 7'h50, 1'b0, 12);
        drain();

        // load e8 vl=5 into v3 (all ones): tail bytes undisturbed
        exp_mem(1'b0, 32'h200, 4'hF, 32'd0);
        exp_mem(1'b0, 32'h204, 4'h1, 32'd0);
        exp_rf(5'd3, 128'hFFFFFFFF_FFFFFFFF_FFFFFFB3_A0A1A2A3);
        issue(1'b0, 5'd3, 32'h200, 9'd5, 7'h40, 1'b0, 8);
        drain();

        // store e16 vl=3 from v7
        exp_mem(1'b1, 32'h300, 4'hF, 32'h11110000);
        exp_mem(1'b1, 32'h304, 4'h3, 32'h33332222);
        issue(1'b1, 5'd7, 32'h300, 9'd3, 7'h48, 1'b0, 5);
        drain();

        // rejected commands and vl=0: no memory access, done two cycles after accept
        issue(1'b0, 5'd2, 32'h102, 9'd4, 7'h50, 1'b1, 2);
        drain();
        issue(1'b0, 5'd2, 32'h100, 9'd4, 7'h00, 1'b1, 2);
        drain();
        issue(1'b1, 5'd2, 32'h100, 9'd4, 7'h58, 1'b1, 2);
        drain();
        issue(1'b0, 5'd2, 32'h100, 9'd4, 7'h51, 1'b1, 2);
        drain();
        issue(1'b0, 5'd2, 32'h100, 9'd0, 7'h50, 1'b0, 2);
        drain();

        // vl beyond VLMAX is clamped to a full register
        for (int k = 0; k < 4; k++) exp_mem(1'b1, 32'h400 + 32'(4 * k), 4'hF, V7[32*k +: 32]);
        issue(1'b1, 5'd7, 32'h400, 9'd100, 7'h50, 1'b0, 7);
        drain();

        // grant withheld 5 cycles on beat 2: payload checked every cycle it is held
        stall_addr = 32'h508;
        stall_len  = 5;
        for (int k = 0; k < 4; k++) exp_mem(1'b1, 32'h500 + 32'(4 * k), 4'hF, V7[32*k +: 32]);
        issue(1'b1, 5'd7, 32'h500, 9'd4, 7'h50, 1'b0, 12);
        drain();

        // reset in the middle of a load
        for (int k = 0; k < 4; k++) exp_mem(1'b0, 32'h600 + 32'(4 * k), 4'hF, 32'd0);
        issue(1'b0, 5'd9, 32'h600, 9'd4, 7'h50, 1'b0, 12);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_mem_q.delete();
        exp_rf_q.delete();
        exp_done_q.delete();
        chk("midrst_mem_req", {127'd0, mem_req}, 128'd0);
        chk("midrst_rf_wen", {127'd0, rf_wen}, 128'd0);
        chk("midrst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_mem(1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'd0);
        exp_rf(5'd10, 128'h44444444_33333333_22222222_11111111);
        issue(1'b0, 5'd10, 32'h100, 9'd4, 7'h50, 1'b0, 12);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
